gin_id_cfg_ctrl: RTL and testbench

- Configuration controller for the global input network (GIN) row/column tag-ID scan chain.
- Fetches ID configuration words from a config stream and serialises them LSB-first into si_id with se_id asserted. It captures the displaced old chain contents from so_id as readback words.
- Blocks GIN data traffic while configuring: it holds the source-side enable/ready and waits for the GIN to drain before shifting begins.
- Sits between the top-level config port / GLB source and the GIN's se_id/si_id/so_id and enable_in/ready_out.

---
 rtl/gin_id_cfg_ctrl_if.sv | 33 +++
 rtl/gin_id_cfg_ctrl.sv | 114 +++++++++++
 tb/tb_gin_id_cfg_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gin_id_cfg_ctrl_if.sv
// Bundle of config-stream, readback, scan-chain and GIN pass-through signals
// seen by the GIN ID configuration controller.
interface gin_id_cfg_ctrl_if #(
    parameter int CFG_WORD_WIDTH = 16
);
    logic                      cfg_start;
    logic [CFG_WORD_WIDTH-1:0] cfg_word_in;
    logic                      cfg_word_valid;
    logic                      cfg_word_ready;
    logic [CFG_WORD_WIDTH-1:0] rd_word;
    logic                      rd_valid;
    logic                      cfg_busy;
    logic                      cfg_done;
    logic                      se_id;
    logic                      si_id;
    logic                      so_id;
    logic                      src_enable;
    logic                      src_ready;
    logic                      gin_enable_in;
    logic                      gin_ready_out;

    modport master (
        input  cfg_start, cfg_word_in, cfg_word_valid, so_id, src_enable, gin_ready_out,
        output cfg_word_ready, rd_word, rd_valid, cfg_busy, cfg_done, se_id, si_id,
               src_ready, gin_enable_in
    );

    modport slave (
        output cfg_start, cfg_word_in, cfg_word_valid, so_id, src_enable, gin_ready_out,
        input  cfg_word_ready, rd_word, rd_valid, cfg_busy, cfg_done, se_id, si_id,
               src_ready, gin_enable_in
    );
endinterface

// File: rtl/gin_id_cfg_ctrl.sv
// GIN row/column ID scan-chain reload controller: drains GIN traffic, then shifts
// config words LSB-first into the chain while capturing the displaced bits.
module gin_id_cfg_ctrl #(
    parameter int CHAIN_LEN      = 1008,
    parameter int CFG_WORD_WIDTH = 16,
    parameter int CNT_WIDTH      = 10
) (
    input  logic                link_clk,
    input  logic                reset,
    gin_id_cfg_ctrl_if.master   bus,
    output logic [2:0]          dbg_state_o
);
    localparam int W     = CFG_WORD_WIDTH;
    localparam int IDX_W = $clog2(W + 1);
    localparam logic [CNT_WIDTH-1:0] CHAIN_LEN_C = CNT_WIDTH'(CHAIN_LEN);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_DRAIN = 3'd1,
        ST_LOAD  = 3'd2,
        ST_SHIFT = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    state_e               state_q;
    logic [CNT_WIDTH-1:0] bit_cnt_q;
    logic [W-1:0]         shift_q;
    logic [W-1:0]         cap_q;
    logic [W-1:0]         rd_word_q;
    logic                 rd_valid_q;
    logic [IDX_W-1:0]     nb_q;
    logic [IDX_W-1:0]     idx_q;

    logic [CNT_WIDTH-1:0] remain_d;
    logic [CNT_WIDTH-1:0] bit_cnt_d;
    logic [IDX_W-1:0]     nb_d;
    logic [W-1:0]         cap_d;
    logic                 last_bit_d;

    // The last word of the chain may be partial; nb is fixed when the word is taken.
    always_comb begin
        remain_d   = CHAIN_LEN_C - bit_cnt_q;
        bit_cnt_d  = bit_cnt_q + CNT_WIDTH'(1);
        nb_d       = IDX_W'(W);
        if (int'(remain_d) < W) nb_d = IDX_W'(remain_d);
        cap_d      = cap_q | (W'(bus.so_id) << idx_q);
        last_bit_d = (idx_q == (nb_q - IDX_W'(1)));
    end

    always_ff @(posedge link_clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            cap_q      <= '0;
            rd_word_q  <= '0;
            rd_valid_q <= 1'b0;
            nb_q       <= '0;
            idx_q      <= '0;
        end else begin
            rd_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.cfg_start) state_q <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (bus.gin_ready_out) state_q <= ST_LOAD;
                end
                ST_LOAD: begin
                    if (bus.cfg_word_valid) begin
                        shift_q <= bus.cfg_word_in;
                        nb_q    <= nb_d;
                        idx_q   <= '0;
                        cap_q   <= '0;
                        state_q <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    shift_q   <= shift_q >> 1;
                    cap_q     <= cap_d;
                    bit_cnt_q <= bit_cnt_d;
                    idx_q     <= idx_q + IDX_W'(1);
                    if (last_bit_d) begin
                        rd_word_q  <= cap_d;
                        rd_valid_q <= 1'b1;
                        state_q    <= (bit_cnt_d == CHAIN_LEN_C) ? ST_DONE : ST_LOAD;
                    end
                end
                ST_DONE: begin
                    bit_cnt_q <= '0;
                    state_q   <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Config stream: a word transfers on a cycle where cfg_word_valid && cfg_word_ready;
    // ready is high only in LOAD, so valid held outside LOAD never consumes a word.
    // Readback has no backpressure: rd_valid is a single-cycle pulse.
    assign bus.cfg_word_ready = (state_q == ST_LOAD);
    assign bus.se_id          = (state_q == ST_SHIFT);
    assign bus.si_id          = (state_q == ST_SHIFT) & shift_q[0];
    assign bus.cfg_busy       = (state_q != ST_IDLE);
    assign bus.cfg_done       = (state_q == ST_DONE);
    assign bus.rd_word        = rd_word_q;
    assign bus.rd_valid       = rd_valid_q;

    // Data traffic only flows while idle; everywhere else the source is held off.
    assign bus.gin_enable_in  = (state_q == ST_IDLE) & bus.src_enable;
    assign bus.src_ready      = (state_q == ST_IDLE) & bus.gin_ready_out;

    assign dbg_state_o        = state_q;
endmodule

// File: tb/tb_gin_id_cfg_ctrl.sv
// Directed bench for gin_id_cfg_ctrl with a 10-bit chain of 4-bit words and a
// behavioural scan-chain model on si_id/so_id.
module tb_gin_id_cfg_ctrl;
  localparam int CHAIN_LEN = 10;
  localparam int W         = 4;
  localparam int CNT_WIDTH = 4;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_DRAIN = 3'd1;
  localparam logic [2:0] S_LOAD  = 3'd2;

  // ---------------- clock / reset ----------------
  logic link_clk = 1'b0;
  logic reset    = 1'b1;
  logic [2:0] dbg_state;

  always #5 link_clk = ~link_clk;

  gin_id_cfg_ctrl_if #(.CFG_WORD_WIDTH(W)) bus ();

  gin_id_cfg_ctrl #(
    .CHAIN_LEN(CHAIN_LEN),
    .CFG_WORD_WIDTH(W),
    .CNT_WIDTH(CNT_WIDTH)
  ) dut (
    .link_clk(link_clk),
    .reset(reset),
    .bus(bus.master),
    .dbg_state_o(dbg_state)
  );

  // ---------------- scan-chain model ----------------
  logic [CHAIN_LEN-1:0] chain = '0;
  bit preload = 1'b0;

  always @(posedge link_clk) begin
    if (preload) chain <= 10'h2AB;
    else if (bus.se_id) chain <= {bus.si_id, chain[CHAIN_LEN-1:1]};
  end

  assign bus.so_id = chain[0];

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad   = 0;
  logic         si_log[$];
  logic [W-1:0] rd_log[$];
  logic [W-1:0] exp_q[$];
  int se_cnt   = 0;
  int done_cnt = 0;

  logic [W-1:0] words [3] = '{4'hA, 4'h5, 4'h3};
  logic [CHAIN_LEN-1:0] exp_si    = 10'h35A;  // bit k is the k-th si_id bit
  logic [CHAIN_LEN-1:0] exp_chain = 10'h35A;

  int shifts_seen;
  int stall_seen;
  int stall_shifts;
  int stall_se_bad;
  bit fed_timeout;

  always @(negedge link_clk) begin
    if (bus.se_id) begin
      si_log.push_back(bus.si_id);
      se_cnt++;
    end
    if (bus.rd_valid) rd_log.push_back(bus.rd_word);
    if (bus.cfg_done) done_cnt++;
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge link_clk);
    #1;
  endtask

  task automatic clear_logs();
    si_log.delete();
    rd_log.delete();
    se_cnt   = 0;
    done_cnt = 0;
  endtask

  task automatic load_chain();
    preload = 1'b1;
    tick();
    preload = 1'b0;
  endtask

  task automatic start_cfg();
    bus.cfg_start = 1'b1;
    tick();
    bus.cfg_start = 1'b0;
  endtask

  task automatic feed_words(input int stall, input int abort_after, input bit poke);
    int widx = 0;
    int stall_left = stall;
    int budget = 300;
    bit hs;
    bit stalling;
    shifts_seen  = 0;
    stall_seen   = 0;
    stall_shifts = -1;
    stall_se_bad = 0;
    fed_timeout  = 1'b0;
    while (!bus.cfg_done && budget > 0) begin
      stalling = (widx == 1) && (stall_left > 0);
      bus.cfg_word_valid = (widx < 3) && !stalling;
      bus.cfg_word_in    = words[(widx < 3) ? widx : 0];
      if (stalling && bus.cfg_word_ready) begin
        stall_left--;
        stall_seen++;
        stall_shifts = se_cnt;
        if (bus.se_id) stall_se_bad++;
      end
      hs = bus.cfg_word_valid && bus.cfg_word_ready;
      tick();
      budget--;
      if (hs) widx++;
      if (bus.se_id) shifts_seen++;
      bus.cfg_start = poke && bus.se_id;
      if (abort_after > 0 && shifts_seen == abort_after) begin
        bus.cfg_word_valid = 1'b0;
        return;
      end
    end
    bus.cfg_word_valid = 1'b0;
    bus.cfg_start      = 1'b0;
    if (budget == 0) fed_timeout = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    bus.cfg_start = 0; bus.cfg_word_in = '0; bus.cfg_word_valid = 0;
    bus.src_enable = 0; bus.gin_ready_out = 0;
    reset = 1'b1;
    tick(); tick();
    total++; if (bus.se_id !== 1'b0) begin bad++; $display("FAIL reset_se_id got=%b want=0", bus.se_id); end
    total++; if (bus.si_id !== 1'b0) begin bad++; $display("FAIL reset_si_id got=%b want=0", bus.si_id); end
    total++; if (bus.cfg_word_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b want=0", bus.cfg_word_ready); end
    total++; if (bus.rd_word !== 4'h0) begin bad++; $display("FAIL reset_rd_word got=%h want=0", bus.rd_word); end
    total++; if (bus.rd_valid !== 1'b0) begin bad++; $display("FAIL reset_rd_valid got=%b want=0", bus.rd_valid); end
    total++; if (bus.cfg_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", bus.cfg_busy); end
    total++; if (bus.cfg_done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", bus.cfg_done); end
    total++; if (dbg_state !== S_IDLE) begin bad++; $display("FAIL reset_state got=%0d want=%0d", dbg_state, S_IDLE); end
    reset = 1'b0;
    tick();
    bus.src_enable = 1'b1; bus.gin_ready_out = 1'b1;
    #1;
    total++; if (bus.gin_enable_in !== 1'b1) begin bad++; $display("FAIL pass_enable got=%b want=1", bus.gin_enable_in); end
    total++; if (bus.src_ready !== 1'b1) begin bad++; $display("FAIL pass_ready got=%b want=1", bus.src_ready); end
    total++; if (bus.se_id !== 1'b0) begin bad++; $display("FAIL pass_se_id got=%b want=0", bus.se_id); end
    bus.src_enable = 1'b0; bus.gin_ready_out = 1'b0;
    #1;
    total++; if (bus.gin_enable_in !== 1'b0) begin bad++; $display("FAIL pass_enable_low got=%b want=0", bus.gin_enable_in); end
    total++; if (bus.src_ready !== 1'b0) begin bad++; $display("FAIL pass_ready_low got=%b want=0", bus.src_ready); end
    bus.gin_ready_out = 1'b1;
    tick();
  endtask

  task automatic test_basic_reload();
    logic got;
    logic [W-1:0] gotw;
    load_chain();
    clear_logs();
    start_cfg();
    feed_words(0, 0, 1'b0);
    tick();
    total++; if (fed_timeout !== 1'b0) begin bad++; $display("FAIL basic_timeout got=1 want=0"); end
    total++; if (se_cnt !== CHAIN_LEN) begin bad++; $display("FAIL basic_se_cycles got=%0d want=%0d", se_cnt, CHAIN_LEN); end
    for (int k = 0; k < CHAIN_LEN; k++) begin
      got = (k < si_log.size()) ? si_log[k] : 1'bx;
      total++; if (got !== exp_si[k]) begin bad++; $display("FAIL basic_si[%0d] got=%b want=%b", k, got, exp_si[k]); end
    end
    exp_q = '{4'hB, 4'hA, 4'h2};
    total++; if (rd_log.size() !== 3) begin bad++; $display("FAIL basic_rd_count got=%0d want=3", rd_log.size()); end
    for (int k = 0; k < 3; k++) begin
      gotw = (k < rd_log.size()) ? rd_log[k] : 4'hx;
      total++; if (gotw !== exp_q[k]) begin bad++; $display("FAIL basic_rd[%0d] got=%h want=%h", k, gotw, exp_q[k]); end
    end
    total++; if (done_cnt !== 1) begin bad++; $display("FAIL basic_done_count got=%0d want=1", done_cnt); end
    total++; if (chain !== exp_chain) begin bad++; $display("FAIL basic_chain got=%h want=%h", chain, exp_chain); end
    total++; if (bus.rd_word !== 4'h2) begin bad++; $display("FAIL basic_rd_hold got=%h want=2", bus.rd_word); end
    total++; if (bus.cfg_busy !== 1'b0) begin bad++; $display("FAIL basic_idle_busy got=%b want=0", bus.cfg_busy); end
  endtask

  task automatic test_drain_wait();
    load_chain();
    clear_logs();
    bus.gin_ready_out = 1'b0;
    bus.src_enable    = 1'b1;
    bus.cfg_start     = 1'b1;
    #1;
    total++; if (bus.gin_enable_in !== 1'b1) begin bad++; $display("FAIL drain_coincide_enable got=%b want=1", bus.gin_enable_in); end
    tick();
    bus.cfg_start = 1'b0;
    for (int c = 0; c < 5; c++) begin
      total++; if (dbg_state !== S_DRAIN) begin bad++; $display("FAIL drain_state[%0d] got=%0d want=%0d", c, dbg_state, S_DRAIN); end
      total++; if (bus.se_id !== 1'b0) begin bad++; $display("FAIL drain_se_id[%0d] got=%b want=0", c, bus.se_id); end
      total++; if (bus.gin_enable_in !== 1'b0) begin bad++; $display("FAIL drain_enable[%0d] got=%b want=0", c, bus.gin_enable_in); end
      total++; if (bus.src_ready !== 1'b0) begin bad++; $display("FAIL drain_src_ready[%0d] got=%b want=0", c, bus.src_ready); end
      total++; if (bus.cfg_busy !== 1'b1) begin bad++; $display("FAIL drain_busy[%0d] got=%b want=1", c, bus.cfg_busy); end
      tick();
    end
    bus.gin_ready_out = 1'b1;
    #1;
    total++; if (bus.src_ready !== 1'b0) begin bad++; $display("FAIL drain_rise_src_ready got=%b want=0", bus.src_ready); end
    tick();
    total++; if (dbg_state !== S_LOAD) begin bad++; $display("FAIL drain_to_load got=%0d want=%0d", dbg_state, S_LOAD); end
    total++; if (bus.cfg_word_ready !== 1'b1) begin bad++; $display("FAIL drain_load_ready got=%b want=1", bus.cfg_word_ready); end
    bus.src_enable = 1'b0;
    feed_words(0, 0, 1'b0);
    tick();
    total++; if (fed_timeout !== 1'b0) begin bad++; $display("FAIL drain_timeout got=1 want=0"); end
    total++; if (done_cnt !== 1) begin bad++; $display("FAIL drain_done_count got=%0d want=1", done_cnt); end
    total++; if (chain !== exp_chain) begin bad++; $display("FAIL drain_chain got=%h want=%h", chain, exp_chain); end
  endtask

  task automatic test_word_stall();
    logic got;
    load_chain();
    clear_logs();
    start_cfg();
    feed_words(3, 0, 1'b0);
    tick();
    total++; if (fed_timeout !== 1'b0) begin bad++; $display("FAIL stall_timeout got=1 want=0"); end
    total++; if (stall_seen !== 3) begin bad++; $display("FAIL stall_cycles got=%0d want=3", stall_seen); end
    total++; if (stall_se_bad !== 0) begin bad++; $display("FAIL stall_se_id got=%0d want=0", stall_se_bad); end
    total++; if (stall_shifts !== W) begin bad++; $display("FAIL stall_frozen got=%0d want=%0d", stall_shifts, W); end
    total++; if (se_cnt !== CHAIN_LEN) begin bad++; $display("FAIL stall_se_cycles got=%0d want=%0d", se_cnt, CHAIN_LEN); end
    for (int k = 0; k < CHAIN_LEN; k++) begin
      got = (k < si_log.size()) ? si_log[k] : 1'bx;
      total++; if (got !== exp_si[k]) begin bad++; $display("FAIL stall_si[%0d] got=%b want=%b", k, got, exp_si[k]); end
    end
    total++; if (chain !== exp_chain) begin bad++; $display("FAIL stall_chain got=%h want=%h", chain, exp_chain); end
  endtask

  task automatic test_reset_mid_shift();
    logic got;
    logic [W-1:0] gotw;
    load_chain();
    clear_logs();
    start_cfg();
    feed_words(0, 6, 1'b0);
    total++; if (bus.se_id !== 1'b1) begin bad++; $display("FAIL midrst_pre_se_id got=%b want=1", bus.se_id); end
    reset = 1'b1;
    #1;
    total++; if (bus.se_id !== 1'b0) begin bad++; $display("FAIL midrst_se_id got=%b want=0", bus.se_id); end
    total++; if (bus.si_id !== 1'b0) begin bad++; $display("FAIL midrst_si_id got=%b want=0", bus.si_id); end
    total++; if (bus.cfg_busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%b want=0", bus.cfg_busy); end
    total++; if (bus.rd_word !== 4'h0) begin bad++; $display("FAIL midrst_rd_word got=%h want=0", bus.rd_word); end
    total++; if (bus.cfg_word_ready !== 1'b0) begin bad++; $display("FAIL midrst_ready got=%b want=0", bus.cfg_word_ready); end
    total++; if (bus.cfg_done !== 1'b0) begin bad++; $display("FAIL midrst_done got=%b want=0", bus.cfg_done); end
    tick();
    reset = 1'b0;
    tick();
    load_chain();
    clear_logs();
    start_cfg();
    feed_words(0, 0, 1'b0);
    tick();
    total++; if (fed_timeout !== 1'b0) begin bad++; $display("FAIL midrst_timeout got=1 want=0"); end
    total++; if (se_cnt !== CHAIN_LEN) begin bad++; $display("FAIL midrst_se_cycles got=%0d want=%0d", se_cnt, CHAIN_LEN); end
    for (int k = 0; k < CHAIN_LEN; k++) begin
      got = (k < si_log.size()) ? si_log[k] : 1'bx;
      total++; if (got !== exp_si[k]) begin bad++; $display("FAIL midrst_si[%0d] got=%b want=%b", k, got, exp_si[k]); end
    end
    exp_q = '{4'hB, 4'hA, 4'h2};
    for (int k = 0; k < 3; k++) begin
      gotw = (k < rd_log.size()) ? rd_log[k] : 4'hx;
      total++; if (gotw !== exp_q[k]) begin bad++; $display("FAIL midrst_rd[%0d] got=%h want=%h", k, gotw, exp_q[k]); end
    end
    total++; if (done_cnt !== 1) begin bad++; $display("FAIL midrst_done_count got=%0d want=1", done_cnt); end
  endtask

  task automatic test_start_during_shift();
    load_chain();
    clear_logs();
    start_cfg();
    feed_words(0, 0, 1'b1);
    for (int c = 0; c < 4; c++) tick();
    total++; if (fed_timeout !== 1'b0) begin bad++; $display("FAIL poke_timeout got=1 want=0"); end
    total++; if (done_cnt !== 1) begin bad++; $display("FAIL poke_done_count got=%0d want=1", done_cnt); end
    total++; if (se_cnt !== CHAIN_LEN) begin bad++; $display("FAIL poke_se_cycles got=%0d want=%0d", se_cnt, CHAIN_LEN); end
    total++; if (bus.cfg_busy !== 1'b0) begin bad++; $display("FAIL poke_idle_busy got=%b want=0", bus.cfg_busy); end
    total++; if (chain !== exp_chain) begin bad++; $display("FAIL poke_chain got=%h want=%h", chain, exp_chain); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_basic_reload();
    test_drain_wait();
    test_word_stall();
    test_reset_mid_shift();
    test_start_during_shift();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
